mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM that sequences the shared-ALU / single-memory 32-bit MIPS datapath in cpu_32_board.
//  Decodes opcode/funct and drives every datapath enable and mux select, one state per cycle.
//  Stretches memory states on mem_ready and flags illegal instructions and memory timeouts.
//  Sits beside the datapath inside the top-level CPU; the board testbench observes state, instr_done and bus_err.
// PARAMETERS
//  WAIT_MAX  15  cycles mem_ready may stay low in one memory state before bus_err (1..255)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  opcode     in   6  IR[31:26]
//  funct      in   6  IR[5:0]
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completes current access this cycle
//  pc_we      out  1  PC write enable (includes taken branch)
//  pc_src     out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
//  iord       out  1  0=PC addresses memory, 1=ALUOut addresses memory
//  mem_rd     out  1  memory read strobe
//  mem_wr     out  1  memory write strobe
//  ir_we      out  1  instruction register load
//  reg_dst    out  1  0=rt, 1=rd
//  mem_to_reg out  1  0=ALUOut, 1=MDR to register file
//  reg_we     out  1  register file write enable
//  alu_src_a  out  1  0=PC, 1=A
//  alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=(sign-ext imm)<<2
//  alu_ctrl   out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT
//  state      out  4  current state code (debug)
//  instr_done out  1  one-cycle pulse when an instruction retires
//  illegal    out  1  one-cycle pulse on an unsupported opcode/funct
//  bus_err    out  1  sticky memory-timeout flag, cleared only by rst
// BEHAVIOUR
//  Clock clk and reset rst: one clock; reset is asynchronous and active-high.
//  Reset: state=FETCH, wait counter=0, instr_done/illegal/bus_err=0. While rst=1, all enables/strobes are forced 0.
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 IMMEX=9 IMMWB=10 JUMP=11 HALT=12.
//  FETCH:  mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, ADD. On mem_ready: ir_we=1, pc_we=1, pc_src=0, go to DECODE; otherwise stay.
//  DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Dispatch on opcode:
//    lw 0x23 or sw 0x2B -> MEMADR; R-type 0x00 -> EXEC; beq 0x04 or bne 0x05 -> BRANCH;
//    addi 0x08 or ori 0x0D -> IMMEX; j 0x02 -> JUMP; anything else -> illegal pulse, then FETCH.
//  MEMADR: alu_src_a=1, alu_src_b=2, ADD; lw -> MEMRD, sw -> MEMWR.
//  MEMRD:  mem_rd=1, iord=1; on mem_ready -> MEMWB.
//  MEMWB:  reg_we=1, reg_dst=0, mem_to_reg=1; instr_done; -> FETCH.
//  MEMWR:  mem_wr=1, iord=1; on mem_ready: instr_done, -> FETCH.
//  EXEC:   alu_src_a=1, alu_src_b=0; funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT -> ALUWB.
//          Any other funct: illegal pulse, -> FETCH, no register write.
//  ALUWB:  reg_we=1, reg_dst=1, mem_to_reg=0; instr_done; -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_we = (beq & zero) | (bne & ~zero); instr_done; -> FETCH.
//  IMMEX:  alu_src_a=1, alu_src_b=2; ADD for addi, OR for ori -> IMMWB.
//  IMMWB:  reg_we=1, reg_dst=0, mem_to_reg=0; instr_done; -> FETCH.
//  JUMP:   pc_we=1, pc_src=2; instr_done; -> FETCH.
//  Wait counter: counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR and clears on any state change.
//    When it reaches WAIT_MAX: bus_err<=1 and go to HALT.
//  HALT: every enable/strobe 0; only rst leaves it.
//  Unlisted outputs are 0 in every state. Outputs are combinational from state, opcode, funct, zero and mem_ready.
//  A stalled memory state holds every output steady.
//  Opcode/funct are sampled from IR; the IR is stable after FETCH, so the FSM latches the opcode class in DECODE.
//  rst mid-instruction: abort immediately, no partial write is completed, restart at FETCH.
// STRUCTURE
//  Shared package cpu_ctrl_pkg: state codes, opcode/funct constants, ALU_* codes, PCSRC_*/ALUB_* select codes.
//  One natural sub-module: mips_alu_decode (combinational funct/opcode -> alu_ctrl + legal flag).
// TESTING
//  1. rst pulse, mem_ready=1, opcode=0x23 -> states 0,1,2,3,4; reg_we=1 and mem_to_reg=1 in state 4; instr_done once.
//  2. opcode=0, funct=0x22 -> EXEC alu_ctrl=1; ALUWB reg_dst=1, reg_we=1; 4 cycles total.
//  3. beq with zero=1 -> pc_we=1, pc_src=1 in BRANCH. Same with zero=0 -> pc_we=0. bne gives the opposite result.
//  4. mem_ready low 5 cycles in MEMWR -> mem_wr held 6 cycles, state stays 5, no bus_err.
//  5. mem_ready held low 15 cycles in FETCH -> bus_err=1, state=12, all enables 0 until rst.
//  6. opcode=0x3F -> illegal pulse in DECODE, back to FETCH, no reg_we/mem_wr; rst asserted in MEMRD -> state 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: state codes, opcode/funct constants, ALU operation codes,
// PC-source and ALU-B select codes, and the latched opcode class.
package mips_multicycle_ctrl_pkg;

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        C_LW, C_SW, C_RTYPE, C_BEQ, C_BNE, C_ADDI, C_ORI, C_J
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_B     = 2'd0;
    localparam logic [1:0] ALUB_4     = 2'd1;
    localparam logic [1:0] ALUB_IMM   = 2'd2;
    localparam logic [1:0] ALUB_IMMSH = 2'd3;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle FSM and the datapath.
// master: the control FSM (consumes IR fields and status, drives controls).
// slave:  the datapath side (drives IR fields and status, consumes controls).
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_ctrl, state, instr_done,
               illegal, bus_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_ctrl, state, instr_done,
               illegal, bus_err
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Combinational instruction decode for the control FSM.
// Ports: opcode/funct in; funct_alu + funct_ok (R-type ALU op and legality),
// op_class + op_ok (opcode class and legality) out.
module mips_multicycle_ctrl_alu_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] funct_alu,
    output logic       funct_ok,
    output op_class_t  op_class,
    output logic       op_ok
);

    // R-type funct -> ALU operation
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // opcode -> instruction class
    always_comb begin
        op_class = C_LW;
        op_ok    = 1'b1;
        case (opcode)
            OP_LW:    op_class = C_LW;
            OP_SW:    op_class = C_SW;
            OP_RTYPE: op_class = C_RTYPE;
            OP_BEQ:   op_class = C_BEQ;
            OP_BNE:   op_class = C_BNE;
            OP_ADDI:  op_class = C_ADDI;
            OP_ORI:   op_class = C_ORI;
            OP_J:     op_class = C_J;
            default:  op_ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the shared-ALU / single-memory MIPS datapath.
// Ports: clk, rst (async, active-high); bus (master modport) carrying
// opcode/funct/zero/mem_ready in and all datapath controls plus
// state/instr_done/illegal/bus_err out. Controls are combinational from the
// state and live inputs so memory handshakes act in the same cycle.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input logic                   clk,
    input logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state_q;
    op_class_t        cls_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic             bus_err_q;

    logic [2:0] funct_alu;
    logic       funct_ok;
    op_class_t  dec_cls;
    logic       op_ok;
    logic       mem_state;
    logic       stall;
    logic       timeout;

    mips_multicycle_ctrl_alu_decode u_dec (
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .funct_alu (funct_alu),
        .funct_ok  (funct_ok),
        .op_class  (dec_cls),
        .op_ok     (op_ok)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign stall     = mem_state && !bus.mem_ready;
    // the WAIT_MAX-th consecutive stalled cycle is the one that gives up
    assign timeout   = stall && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    // state register, wait counter, sticky error and latched opcode class
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_LW;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else if (timeout) begin
            state_q   <= S_HALT;
            wait_cnt  <= '0;
            bus_err_q <= 1'b1;
        end else if (stall) begin
            wait_cnt  <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    cls_q <= dec_cls;
                    if (!op_ok) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (dec_cls)
                            C_LW, C_SW:     state_q <= S_MEMADR;
                            C_RTYPE:        state_q <= S_EXEC;
                            C_BEQ, C_BNE:   state_q <= S_BRANCH;
                            C_ADDI, C_ORI:  state_q <= S_IMMEX;
                            default:        state_q <= S_JUMP;
                        endcase
                    end
                end
                S_MEMADR: state_q <= (cls_q == C_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXEC:   state_q <= funct_ok ? S_ALUWB : S_FETCH;
                S_IMMEX:  state_q <= S_IMMWB;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.bus_err = bus_err_q;

    // per-state datapath controls; everything idles while rst is held
    always_comb begin
        bus.pc_we      = 1'b0;
        bus.pc_src     = PCSRC_ALU;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_we     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ALUB_B;
        bus.alu_ctrl   = ALU_ADD;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_rd    = 1'b1;
                    bus.alu_src_b = ALUB_4;
                    bus.ir_we     = bus.mem_ready;
                    bus.pc_we     = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = ALUB_IMMSH;
                    bus.illegal   = !op_ok;
                end
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUB_IMM;
                end
                S_MEMRD: begin
                    bus.mem_rd = 1'b1;
                    bus.iord   = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_we     = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_wr     = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_ctrl  = funct_alu;
                    bus.illegal   = !funct_ok;
                end
                S_ALUWB: begin
                    bus.reg_we     = 1'b1;
                    bus.reg_dst    = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_ctrl   = ALU_SUB;
                    bus.pc_src     = PCSRC_ALUOUT;
                    bus.pc_we      = ((cls_q == C_BEQ) && bus.zero) ||
                                     ((cls_q == C_BNE) && !bus.zero);
                    bus.instr_done = 1'b1;
                end
                S_IMMEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUB_IMM;
                    bus.alu_ctrl  = (cls_q == C_ORI) ? ALU_OR : ALU_ADD;
                end
                S_IMMWB: begin
                    bus.reg_we     = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_we      = 1'b1;
                    bus.pc_src     = PCSRC_JUMP;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is expanded
// into a queue of per-cycle (inputs, expected outputs) steps, then replayed
// against the DUT with a full-vector compare on every cycle.
module tb_mips_multicycle_ctrl;

    localparam int unsigned WAIT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } vec_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zr;
        logic       rdy;
        vec_t       e;
    } step_t;

    step_t q[$];
    int n_chk  = 0;
    int n_fail = 0;
    logic [5:0] cur_op, cur_fn;
    int o_done, o_memwr, o_regwe, o_illegal, o_cycles, o_pcwe;

    logic [5:0] op_pool [10] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05,
                                 6'h08, 6'h0D, 6'h02, 6'h3F};
    logic [5:0] fn_pool [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};

    function automatic vec_t z(input int st);
        vec_t v;
        v    = '0;
        v.st = 4'(st);
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.st = bus.state;         v.pc_we = bus.pc_we;       v.pc_src = bus.pc_src;
        v.iord = bus.iord;        v.mem_rd = bus.mem_rd;     v.mem_wr = bus.mem_wr;
        v.ir_we = bus.ir_we;      v.reg_dst = bus.reg_dst;   v.mem_to_reg = bus.mem_to_reg;
        v.reg_we = bus.reg_we;    v.alu_src_a = bus.alu_src_a;
        v.alu_src_b = bus.alu_src_b; v.alu_ctrl = bus.alu_ctrl;
        v.instr_done = bus.instr_done; v.illegal = bus.illegal; v.bus_err = bus.bus_err;
        return v;
    endfunction

    // ALU code an R-type funct must produce; -1 marks an unsupported funct
    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 0;
            6'h22:   return 1;
            6'h24:   return 2;
            6'h25:   return 3;
            6'h2A:   return 4;
            default: return -1;
        endcase
    endfunction

    task automatic vcheck(input string nm, input vec_t exp);
        vec_t act;
        act = sample();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h (state %0d) required %h (state %0d)",
                     nm, $time, act, act.st, exp, exp.st);
        end
    endtask

    task automatic icheck(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // rdy/zr < 0 means "don't care": drive random values the DUT must ignore
    task automatic push(input vec_t e, input int rdy, input int zr);
        step_t s;
        s.op  = cur_op;
        s.fn  = cur_fn;
        s.rdy = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
        s.zr  = (zr < 0)  ? 1'($urandom_range(0, 1)) : 1'(zr);
        s.e   = e;
        q.push_back(s);
    endtask

    // memory access with s not-ready cycles; gives up after WAIT_MAX of them
    task automatic mem_step(input vec_t stall_v, input vec_t ready_v, input int s,
                            output bit halted);
        vec_t h;
        int   n;
        n      = (s >= int'(WAIT_MAX)) ? int'(WAIT_MAX) : s;
        halted = 1'b0;
        for (int i = 0; i < n; i++) push(stall_v, 0, -1);
        if (s >= int'(WAIT_MAX)) begin
            halted    = 1'b1;
            h         = z(12);
            h.bus_err = 1'b1;
            for (int i = 0; i < 4; i++) push(h, -1, -1);
        end else begin
            push(ready_v, 1, -1);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                             input int fs, input int ms, output bit halted);
        vec_t a, b;
        bit   legal;
        int   alu;
        cur_op = op;
        cur_fn = fn;
        a = z(0); a.mem_rd = 1'b1; a.alu_src_b = 2'd1;
        b = a;    b.ir_we = 1'b1;  b.pc_we = 1'b1;
        mem_step(a, b, fs, halted);
        if (halted) return;
        legal = op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};
        a = z(1); a.alu_src_b = 2'd3; a.illegal = !legal;
        push(a, -1, -1);
        if (!legal) return;
        case (op)
            6'h23, 6'h2B: begin
                a = z(2); a.alu_src_a = 1'b1; a.alu_src_b = 2'd2;
                push(a, -1, -1);
                if (op == 6'h23) begin
                    a = z(3); a.mem_rd = 1'b1; a.iord = 1'b1;
                    mem_step(a, a, ms, halted);
                    if (halted) return;
                    b = z(4); b.reg_we = 1'b1; b.mem_to_reg = 1'b1; b.instr_done = 1'b1;
                    push(b, -1, -1);
                end else begin
                    a = z(5); a.mem_wr = 1'b1; a.iord = 1'b1;
                    b = a;    b.instr_done = 1'b1;
                    mem_step(a, b, ms, halted);
                end
            end
            6'h00: begin
                alu = alu_of(fn);
                a = z(6); a.alu_src_a = 1'b1;
                a.alu_ctrl = (alu < 0) ? 3'd0 : 3'(alu);
                a.illegal  = (alu < 0);
                push(a, -1, -1);
                if (alu >= 0) begin
                    b = z(7); b.reg_we = 1'b1; b.reg_dst = 1'b1; b.instr_done = 1'b1;
                    push(b, -1, -1);
                end
            end
            6'h04, 6'h05: begin
                a = z(8); a.alu_src_a = 1'b1; a.alu_ctrl = 3'd1; a.pc_src = 2'd1;
                a.pc_we = (op == 6'h04) ? zr : !zr;
                a.instr_done = 1'b1;
                push(a, -1, int'(zr));
            end
            6'h08, 6'h0D: begin
                a = z(9); a.alu_src_a = 1'b1; a.alu_src_b = 2'd2;
                a.alu_ctrl = (op == 6'h0D) ? 3'd3 : 3'd0;
                push(a, -1, -1);
                b = z(10); b.reg_we = 1'b1; b.instr_done = 1'b1;
                push(b, -1, -1);
            end
            default: begin
                a = z(11); a.pc_we = 1'b1; a.pc_src = 2'd2; a.instr_done = 1'b1;
                push(a, -1, -1);
            end
        endcase
    endtask

    task automatic clr_obs();
        o_done = 0; o_memwr = 0; o_regwe = 0; o_illegal = 0; o_cycles = 0; o_pcwe = 0;
    endtask

    // replay n queued cycles: drive at negedge, compare 1 time unit later
    task automatic play_n(input int n);
        step_t s;
        vec_t  v;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s             = q.pop_front();
            bus.opcode    = s.op;
            bus.funct     = s.fn;
            bus.zero      = s.zr;
            bus.mem_ready = s.rdy;
            #1;
            v = sample();
            o_cycles++;
            o_done    += int'(v.instr_done);
            o_memwr   += int'(v.mem_wr);
            o_regwe   += int'(v.reg_we);
            o_illegal += int'(v.illegal);
            o_pcwe    += int'(v.pc_we);
            vcheck("cycle", s.e);
            @(negedge clk);
        end
    endtask

    task automatic play();
        play_n(q.size());
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'($urandom);
        #1;
        vcheck("reset", z(0));
        @(negedge clk);
        vcheck("reset_hold", z(0));
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bit h;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // lw with no stalls: five states, one retire
        clr_obs(); gen_instr(6'h23, 6'h00, 1'b0, 0, 0, h); play();
        icheck("lw_cycles", o_cycles, 5);
        icheck("lw_done", o_done, 1);
        icheck("lw_regwe", o_regwe, 1);

        // R-type sub: four cycles
        clr_obs(); gen_instr(6'h00, 6'h22, 1'b0, 0, 0, h); play();
        icheck("sub_cycles", o_cycles, 4);
        icheck("sub_done", o_done, 1);

        // branches: pc_we from FETCH plus one more only when taken
        clr_obs(); gen_instr(6'h04, 6'h00, 1'b1, 0, 0, h); play();
        icheck("beq_z1_pcwe", o_pcwe, 2);
        clr_obs(); gen_instr(6'h04, 6'h00, 1'b0, 0, 0, h); play();
        icheck("beq_z0_pcwe", o_pcwe, 1);
        clr_obs(); gen_instr(6'h05, 6'h00, 1'b1, 0, 0, h); play();
        icheck("bne_z1_pcwe", o_pcwe, 1);
        clr_obs(); gen_instr(6'h05, 6'h00, 1'b0, 0, 0, h); play();
        icheck("bne_z0_pcwe", o_pcwe, 2);

        // sw stalled 5 cycles: mem_wr held for 6
        clr_obs(); gen_instr(6'h2B, 6'h00, 1'b0, 0, 5, h); play();
        icheck("sw_memwr", o_memwr, 6);
        icheck("sw_err", int'(bus.bus_err), 0);

        // one stall short of the limit in both FETCH and MEMRD
        clr_obs(); gen_instr(6'h23, 6'h00, 1'b0, 14, 14, h); play();
        icheck("edge_done", o_done, 1);
        icheck("edge_err", int'(bus.bus_err), 0);

        // FETCH timeout
        clr_obs(); gen_instr(6'h23, 6'h00, 1'b0, 15, 0, h); play();
        icheck("fetch_to_state", int'(bus.state), 12);
        icheck("fetch_to_err", int'(bus.bus_err), 1);
        do_reset();

        // MEMWR timeout
        clr_obs(); gen_instr(6'h2B, 6'h00, 1'b0, 0, 15, h); play();
        icheck("memwr_to_state", int'(bus.state), 12);
        icheck("memwr_to_done", o_done, 0);
        do_reset();

        // illegal opcode and illegal funct
        clr_obs(); gen_instr(6'h3F, 6'h00, 1'b0, 0, 0, h); play();
        icheck("ill_op_pulse", o_illegal, 1);
        icheck("ill_op_regwe", o_regwe + o_memwr, 0);
        icheck("ill_op_cycles", o_cycles, 2);
        clr_obs(); gen_instr(6'h00, 6'h3F, 1'b0, 0, 0, h); play();
        icheck("ill_fn_pulse", o_illegal, 1);
        icheck("ill_fn_cycles", o_cycles, 3);

        // reset while stalled in MEMRD
        clr_obs(); gen_instr(6'h23, 6'h00, 1'b0, 0, 6, h); play_n(4); q.delete();
        icheck("pre_rst_state", int'(bus.state), 3);
        do_reset();
        icheck("rst_regwe", o_regwe, 0);

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            int fs, ms;
            fs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 4));
            ms = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 4));
            gen_instr(op_pool[$urandom_range(0, 9)], fn_pool[$urandom_range(0, 5)],
                      1'($urandom_range(0, 1)), fs, ms, h);
            play();
            if (h) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
